capture_ramblk_ctrl: RTL and testbench
======================================

// Module: capture_ramblk_ctrl
// PURPOSE
// Parametrised triggered capture buffer: successor to the fixed 32x1024 capture ramblk.
// Stores a filtered stream of DATA_W samples into an internal 2^ADDR_W-deep BRAM.
// Supports one-shot post-trigger capture and circular pre-trigger capture.
// Fabric logic arms and triggers it; software reads it back through a registered read port.
// PARAMETERS
// DATA_W   32  sample/word width
// ADDR_W   10  buffer address width; DEPTH = 2**ADDR_W
// CH_W     8   channel-id width used by the channel filter
// PORTS
// clk          in   1       single clock for all logic and both RAM ports
// rst          in   1       synchronous, active-high reset
// din          in   DATA_W  sample data
// din_valid    in   1       sample qualifier
// din_ch       in   CH_W    channel id of din
// ch_filt_en   in   1       1: accept only din_ch==ch_sel; 0: accept all valid samples
// ch_sel       in   CH_W    channel to capture
// mode         in   1       0: one-shot post-trigger; 1: circular pre-trigger (sampled at arm)
// pretrig_len  in   ADDR_W  pre-trigger sample count, mode 1 only (sampled at arm)
// arm          in   1       1-cycle start pulse
// trig         in   1       trigger, level-sampled each cycle
// rd_en        in   1       read request
// rd_addr      in   ADDR_W  read address
// rd_data      out  DATA_W  read data, 2-cycle latency
// rd_valid     out  1       rd_en delayed 2 cycles
// busy         out  1       high in PRE/WAIT/CAPT
// done         out  1       high in DONE
// start_addr   out  ADDR_W  address of the oldest captured sample, valid when done=1
// BEHAVIOUR
// - accept = din_valid & (~ch_filt_en | din_ch==ch_sel); only accepted samples are written or counted.
// - Reset: state=IDLE; busy=0, done=0, rd_valid=0, rd_data=0, start_addr=0; wr_addr=0.
// - Reset does not clear RAM contents. Reset mid-capture aborts to IDLE.
// - arm is acted on only in IDLE or DONE and is ignored while busy.
// - On arm: latch mode; latch pre = min(pretrig_len, DEPTH-1); clear wr_addr, pre_cnt and done.
// - arm goes to WAIT if mode=0, or to PRE if mode=1.
// - WAIT (mode 0): no writes while trig=0.
//   On trig=1: start_addr=0; post_cnt=DEPTH; go to CAPT in the same cycle.
//   An accepted sample in the trig cycle is written to addr 0 and counts toward post_cnt.
// - PRE (mode 1): each accepted sample is written at wr_addr; wr_addr wraps DEPTH-1 -> 0.
//   pre_cnt (ADDR_W+1 bits) increments on each accept and saturates at DEPTH.
//   trig is honoured only when pre_cnt >= pre; earlier triggers are ignored (no latch).
//   On an honoured trig: start_addr = (wr_addr - pre) mod DEPTH; post_cnt = DEPTH - pre.
//   The trig-cycle sample is the first post-trigger sample. pre=0 in mode 1 equals mode 0 with a nonzero start.
// - CAPT: write each accepted sample at wr_addr, then wr_addr+1 mod DEPTH, then post_cnt-1.
//   When post_cnt goes 1 -> 0 on a write, the state is DONE on the next cycle.
//   trig is ignored in CAPT.
// - DONE: done=1 and start_addr are held; there are no writes.
//   The buffer holds exactly DEPTH samples in order from start_addr, wrapping.
// - Read port: 1-cycle BRAM plus 1 output register, giving 2-cycle latency; reads are allowed in any state.
//   Same-cycle read/write to the same address returns the old data (read-first).
// - A simultaneous arm and rst is resolved as rst.
// - In DONE, an arm pulse restarts with newly sampled mode and pretrig_len.
// TESTING (bench ADDR_W=4, DEPTH=16, din = incrementing counter, valid every cycle, filter off)
// - Mode 0: arm, then trig on din=5 -> done after 16 writes; mem[0..15]=5..20; start_addr=0.
// - Mode 1, pretrig_len=4: arm at din=0, trig on din=10 -> start_addr=6.
//   Required contents: mem[6..15]=6..15 and mem[0..5]=16..21; reading 16 words from addr 6 (wrapping) gives 6..21.
// - Mode 1, pretrig_len=8: trig on din=2 (ignored), busy stays 1; second trig on din=12 -> start_addr=4, done.
// - Filter: ch_filt_en=1, ch_sel=3, din_ch cycling 0..3, mode 0 -> mem holds only ch3 samples.
//   Done occurs after 64 input cycles from the trigger.
// - rst asserted mid-CAPT -> next cycle busy=0, done=0. An arm after that runs a clean capture.
//   rd_en pulse with addr 3 -> rd_valid exactly 2 cycles later with the mem[3] value.

Source files
------------

// File: rtl/capture_ramblk_ctrl.sv
// Triggered capture buffer: filtered sample stream into a 2**ADDR_W-deep BRAM.
// It supports one-shot post-trigger capture and circular pre-trigger capture, with a 2-cycle registered read port.
module capture_ramblk_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int CH_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic [CH_W-1:0]   din_ch,
  input  logic              ch_filt_en,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              mode,
  input  logic [ADDR_W-1:0] pretrig_len,
  input  logic              arm,
  input  logic              trig,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] start_addr
);
  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_N   = (ADDR_W+1)'(DEPTH);
  localparam int              RD_STAGES = 2;

  typedef enum logic [2:0] {IDLE, PRE, WAIT, CAPT, DONE} state_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  state_t            state;
  logic [ADDR_W-1:0] pre_q;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   pre_cnt;
  logic [ADDR_W:0]   post_cnt;
  logic              accept;
  logic              trig_ok;
  logic [ADDR_W:0]   post_wait;
  logic [ADDR_W:0]   post_pre;
  wr_req_t           wr;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [DATA_W-1:0]    ram_q;
  logic [RD_STAGES:1]   vld_pipe;

  assign accept  = din_valid & (~ch_filt_en | (din_ch == ch_sel));
  assign trig_ok = trig & (pre_cnt >= {1'b0, pre_q});

  // Remaining post-trigger samples after the trigger cycle's own sample (if any).
  assign post_wait = DEPTH_N - {{ADDR_W{1'b0}}, accept};
  assign post_pre  = DEPTH_N - {1'b0, pre_q} - {{ADDR_W{1'b0}}, accept};

  always_comb begin
    wr      = '0;
    wr.en   = accept & ((state == PRE) | (state == CAPT) | ((state == WAIT) & trig));
    wr.addr = wr_addr;
    wr.data = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      start_addr <= '0;
      wr_addr    <= '0;
      pre_q      <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
    end else begin
      if (wr.en) wr_addr <= wr_addr + 1'b1;
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            // An ADDR_W-bit length can never exceed DEPTH-1, so no clamp is needed.
            pre_q   <= mode ? pretrig_len : '0;
            wr_addr <= '0;
            pre_cnt <= '0;
            done    <= 1'b0;
            busy    <= 1'b1;
            state   <= mode ? PRE : WAIT;
          end
        end
        WAIT: begin
          if (trig) begin
            start_addr <= '0;
            post_cnt   <= post_wait;
            state      <= CAPT;
          end
        end
        PRE: begin
          if (trig_ok) begin
            start_addr <= wr_addr - pre_q;
            post_cnt   <= post_pre;
            if (post_pre == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= CAPT;
            end
          end else if (accept && pre_cnt != DEPTH_N) begin
            pre_cnt <= pre_cnt + 1'b1;
          end
        end
        CAPT: begin
          if (accept) begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == {{ADDR_W{1'b0}}, 1'b1}) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Plain BRAM: no reset, read-first on a same-address collision.
  always_ff @(posedge clk) begin
    if (wr.en) mem[wr.addr] <= wr.data;
    if (rd_en) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      rd_data  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_STAGES-1:1], rd_en};
      if (vld_pipe[1]) rd_data <= ram_q;
    end
  end

  assign rd_valid = vld_pipe[RD_STAGES];

endmodule

// File: tb/tb_capture_ramblk_ctrl.sv
// Directed bench for capture_ramblk_ctrl at ADDR_W=4: table of capture scenarios with full
// buffer read-back, plus a hand-written reset-abort sequence.
module tb_capture_ramblk_ctrl;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic [CW-1:0] din_ch;
  logic          ch_filt_en;
  logic [CW-1:0] ch_sel;
  logic          mode;
  logic [AW-1:0] pretrig_len;
  logic          arm;
  logic          trig;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;
  logic [AW-1:0] start_addr;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit mode;
    int pre;
    bit filt;
    int trig1;
    int trig2;      // -1: no second trigger
    int exp_start;
    int exp_base;   // value expected at start_addr
    int step;       // din distance between consecutive stored samples
  } vec_t;

  vec_t tbl[6];

  capture_ramblk_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CH_W(CW)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ch(din_ch),
    .ch_filt_en(ch_filt_en), .ch_sel(ch_sel), .mode(mode), .pretrig_len(pretrig_len),
    .arm(arm), .trig(trig), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .start_addr(start_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk($sformatf("%s rd_valid_early[%0d]", tag, a), 32'(rd_valid), 32'd0);
    tick();
    chk($sformatf("%s rd_valid[%0d]", tag, a), 32'(rd_valid), 32'd1);
    chk($sformatf("%s rd_data[%0d]", tag, a), rd_data, exp);
  endtask

  task automatic run_capture(input vec_t v, input string tag);
    int k;
    int done_k;
    ch_filt_en  = v.filt;
    ch_sel      = 8'd3;
    mode        = v.mode;
    pretrig_len = AW'(v.pre);
    din_valid   = 1'b0;
    trig        = 1'b0;
    arm         = 1'b1;
    tick();
    arm = 1'b0;
    chk({tag, " busy_after_arm"}, 32'(busy), 32'd1);
    chk({tag, " done_after_arm"}, 32'(done), 32'd0);
    k      = 0;
    done_k = -1;
    while (done_k < 0 && k < 300) begin
      din       = 32'(k);
      din_ch    = 8'(k % 4);
      din_valid = 1'b1;
      trig      = (k == v.trig1) || (k == v.trig2);
      tick();
      if (v.trig2 >= 0 && k == v.trig1) begin
        chk({tag, " busy_early_trig"}, 32'(busy), 32'd1);
        chk({tag, " done_early_trig"}, 32'(done), 32'd0);
      end
      if (done) done_k = k;
      k++;
    end
    din_valid = 1'b0;
    trig      = 1'b0;
    chk({tag, " done_at_din"}, 32'(done_k), 32'(v.exp_base + v.step * 15));
    chk({tag, " busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, " start_addr"}, 32'(start_addr), 32'(v.exp_start));
    for (int i = 0; i < 16; i++)
      do_read(AW'((v.exp_start + i) % 16), 32'(v.exp_base + v.step * i), tag);
  endtask

  initial begin
    //          mode pre filt trig1 trig2 start base step
    tbl[0] = '{1'b0, 0,  1'b0, 5,  -1,  0,  5,  1};  // one-shot
    tbl[1] = '{1'b1, 4,  1'b0, 10, -1,  6,  6,  1};  // pre-trigger, wrapped buffer
    tbl[2] = '{1'b1, 8,  1'b0, 2,  12,  4,  4,  1};  // early trigger ignored
    tbl[3] = '{1'b1, 0,  1'b0, 7,  -1,  7,  7,  1};  // mode 1 with no pre-trigger
    tbl[4] = '{1'b1, 15, 1'b0, 20, -1,  5,  5,  1};  // max pre: done right after trigger
    tbl[5] = '{1'b0, 0,  1'b1, 8,  -1,  0,  11, 4};  // channel filter, ch3 only

    rst = 1'b1; din = '0; din_valid = 1'b0; din_ch = '0; ch_filt_en = 1'b0; ch_sel = '0;
    mode = 1'b0; pretrig_len = '0; arm = 1'b0; trig = 1'b0; rd_en = 1'b0; rd_addr = '0;
    tick();
    tick();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset rd_data", rd_data, 32'd0);
    chk("reset start_addr", 32'(start_addr), 32'd0);
    rst = 1'b0;
    tick();

    for (int s = 0; s < 6; s++)
      run_capture(tbl[s], $sformatf("vec%0d", s));

    // Abort a capture in progress; the arm issued with rst must lose.
    ch_filt_en = 1'b0;
    mode       = 1'b0;
    arm        = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      din       = 32'(k);
      din_valid = 1'b1;
      trig      = (k == 3);
      tick();
    end
    chk("abort busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    arm = 1'b1;
    tick();
    rst = 1'b0;
    arm = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    tick();
    chk("abort busy_hold", 32'(busy), 32'd0);
    chk("abort done_hold", 32'(done), 32'd0);

    run_capture('{1'b0, 0, 1'b0, 40, -1, 0, 40, 1}, "post_abort");
    do_read(4'd3, 32'd43, "final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
